// File: rtl/eq2.sv
// rtl/eq2.sv - 2-bit comparator with registered compare flags, saturating match/sample counters and sticky mismatch flag
module eq2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             en,
    input  logic             clr,
    output logic             aeqb,
    output logic             aeqb_q,
    output logic             agtb_q,
    output logic             altb_q,
    output logic             mismatch_seen,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             agtb;
    logic             altb;
    logic [CNT_W-1:0] match_cnt_nxt;
    logic [CNT_W-1:0] sample_cnt_nxt;
    logic             mismatch_nxt;

    // Bitwise equality so aeqb never depends on any sequential state.
    assign aeqb = (a[1] ~^ b[1]) & (a[0] ~^ b[0]);
    assign agtb = (a > b);
    assign altb = (a < b);

    // clr takes priority over en so a cleared cycle never counts its own sample.
    always_comb begin
        match_cnt_nxt  = match_cnt;
        sample_cnt_nxt = sample_cnt;
        mismatch_nxt   = mismatch_seen;
        if (clr) begin
            match_cnt_nxt  = '0;
            sample_cnt_nxt = '0;
            mismatch_nxt   = 1'b0;
        end else if (en) begin
            if (sample_cnt != CNT_MAX) begin
                sample_cnt_nxt = sample_cnt + 1'b1;
            end
            if (aeqb && (match_cnt != CNT_MAX)) begin
                match_cnt_nxt = match_cnt + 1'b1;
            end
            if (!aeqb) begin
                mismatch_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aeqb_q        <= 1'b1;
            agtb_q        <= 1'b0;
            altb_q        <= 1'b0;
            mismatch_seen <= 1'b0;
            match_cnt     <= '0;
            sample_cnt    <= '0;
        end else begin
            if (en) begin
                aeqb_q <= aeqb;
                agtb_q <= agtb;
                altb_q <= altb;
            end
            mismatch_seen <= mismatch_nxt;
            match_cnt     <= match_cnt_nxt;
            sample_cnt    <= sample_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_eq2.sv
// tb/tb_eq2.sv - directed self-checking bench for eq2 (default and CNT_W=2 instances)
module tb_eq2;

    logic       clk;
    logic       reset_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       en;
    logic       clr;

    logic       aeqb, aeqb_q, agtb_q, altb_q, mismatch_seen;
    logic [7:0] match_cnt, sample_cnt;
    logic       aeqb_s, aeqb_q_s, agtb_q_s, altb_q_s, mismatch_seen_s;
    logic [1:0] match_cnt_s, sample_cnt_s;

    int checks = 0;
    int errors = 0;

    eq2 #(.CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .en(en), .clr(clr),
        .aeqb(aeqb), .aeqb_q(aeqb_q), .agtb_q(agtb_q), .altb_q(altb_q),
        .mismatch_seen(mismatch_seen), .match_cnt(match_cnt), .sample_cnt(sample_cnt)
    );

    eq2 #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .en(en), .clr(clr),
        .aeqb(aeqb_s), .aeqb_q(aeqb_q_s), .agtb_q(agtb_q_s), .altb_q(altb_q_s),
        .mismatch_seen(mismatch_seen_s), .match_cnt(match_cnt_s), .sample_cnt(sample_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] va [7] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [1:0] vb [7] = '{2'd0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
    logic       exp_eq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_flags [7] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b100, 3'b010};

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        a       = 2'd0;
        b       = 2'd0;
        tick();

        chk("rst_aeqb_q", aeqb_q, 1);
        chk("rst_agtb_q", agtb_q, 0);
        chk("rst_altb_q", altb_q, 0);
        chk("rst_mismatch", mismatch_seen, 0);
        chk("rst_match_cnt", match_cnt, 0);
        chk("rst_sample_cnt", sample_cnt, 0);

        // Combinational vectors, applied while reset is still held.
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            #100;
            chk($sformatf("comb_aeqb_%0d", i), aeqb, exp_eq[i]);
            #100;
        end

        reset_n = 1'b1;
        tick();

        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a = va[i];
            b = vb[i];
            tick();
            chk($sformatf("reg_flags_%0d", i), {aeqb_q, agtb_q, altb_q}, exp_flags[i]);
        end
        en = 1'b0;
        chk("seq_sample_cnt", sample_cnt, 7);
        chk("seq_match_cnt", match_cnt, 3);
        chk("seq_mismatch", mismatch_seen, 1);

        // Hold: en low while operands move.
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            b = 2'(3 - i);
            tick();
            chk($sformatf("hold_flags_%0d", i), {aeqb_q, agtb_q, altb_q}, 3'b010);
            chk($sformatf("hold_sample_%0d", i), sample_cnt, 7);
            chk($sformatf("hold_match_%0d", i), match_cnt, 3);
            chk($sformatf("hold_mismatch_%0d", i), mismatch_seen, 1);
        end

        // clr together with en and a<b.
        en  = 1'b1;
        clr = 1'b1;
        a   = 2'd1;
        b   = 2'd2;
        tick();
        clr = 1'b0;
        en  = 1'b0;
        chk("clr_sample_cnt", sample_cnt, 0);
        chk("clr_match_cnt", match_cnt, 0);
        chk("clr_mismatch", mismatch_seen, 0);
        chk("clr_flags", {aeqb_q, agtb_q, altb_q}, 3'b001);
        chk("clr_sat_sample_cnt", sample_cnt_s, 0);

        // Saturation on the CNT_W=2 instance.
        en = 1'b1;
        a  = 2'd2;
        b  = 2'd2;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("sat_match_%0d", i), match_cnt_s, (i > 3) ? 3 : i);
            chk($sformatf("sat_sample_%0d", i), sample_cnt_s, (i > 3) ? 3 : i);
        end
        chk("sat_wide_match", match_cnt, 5);
        chk("sat_wide_sample", sample_cnt, 5);
        chk("sat_mismatch", mismatch_seen_s, 0);

        // One mismatching sample, then reset mid-sequence.
        a = 2'd3;
        b = 2'd1;
        tick();
        chk("pre_rst_mismatch", mismatch_seen, 1);
        chk("pre_rst_sample", sample_cnt, 6);
        chk("pre_rst_match", match_cnt, 5);
        chk("pre_rst_flags", {aeqb_q, agtb_q, altb_q}, 3'b010);

        reset_n = 1'b0;
        clr     = 1'b0;
        a       = 2'd1;
        b       = 2'd2;
        tick();
        chk("mid_rst_flags", {aeqb_q, agtb_q, altb_q}, 3'b100);
        chk("mid_rst_mismatch", mismatch_seen, 0);
        chk("mid_rst_match", match_cnt, 0);
        chk("mid_rst_sample", sample_cnt, 0);
        chk("mid_rst_aeqb_ne", aeqb, 0);
        a = 2'd1;
        b = 2'd1;
        #1;
        chk("mid_rst_aeqb_eq", aeqb, 1);
        reset_n = 1'b1;
        en      = 1'b0;
        tick();
        chk("post_rst_sample", sample_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
